pentary_regfile_mp: RTL and testbench

- Parametrised multi-port pentary register file, the successor to the fixed 2R/1W file.
- Configurable register count, digit count, read-port count and write-port count.
- Integrated scoreboard, with release folded into writeback.
- Synchronous zero-sweep clear engine, so the array needs no async reset and maps to RAM/flops freely.
- Per-digit encoding check on writes.
- Sits between decode/issue (reads, reserves) and writeback (multiple retiring pipes).

---
 rtl/pentary_regfile_mp_if.sv | 34 +++
 rtl/pentary_regfile_mp.sv | 137 +++++++++++++
 tb/tb_pentary_regfile_mp.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pentary_regfile_mp_if.sv
// rtl/pentary_regfile_mp_if.sv - port bundle for the multi-port pentary register file
interface pentary_regfile_mp_if #(
  parameter int DIGITS   = 16,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
);
  localparam int DATA_W = 3 * DIGITS;

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_WR-1:0]        wr_release;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ok;
  logic                     clear_req;
  logic                     busy;
  logic                     err_sticky;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_release, rsv_en, rsv_addr, clear_req,
    input  rd_data, rd_valid, rsv_ok, busy, err_sticky
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_release, rsv_en, rsv_addr, clear_req,
    output rd_data, rd_valid, rsv_ok, busy, err_sticky
  );
endinterface

// File: rtl/pentary_regfile_mp.sv
// rtl/pentary_regfile_mp.sv - parametrised multi-port pentary register file with scoreboard
module pentary_regfile_mp #(
  parameter int DIGITS   = 16,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  pentary_regfile_mp_if.slave   bus
);
  localparam int DATA_W = 3 * DIGITS;
  localparam logic [ADDR_W:0]   NREG = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                          state_q, state_d;
  logic [ADDR_W-1:0]               ptr_q, ptr_d;
  logic [NUM_REGS-1:0]             sb_q, sb_d;
  logic                            err_q, err_d;
  // The array has no reset; the zero sweep is what initialises it.
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [NUM_WR-1:0] w_ok, w_bad;
  logic [ADDR_W-1:0] ra [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_valid_c;
  logic idle, rsv_ok_c;

  function automatic logic digits_ok(input logic [DATA_W-1:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (d[3*i +: 3] > 3'd4) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NREG;
  endfunction

  assign idle = (state_q == IDLE);

  always_comb begin
    for (int k = 0; k < NUM_WR; k++) begin
      wa[k]    = bus.wr_addr[k*ADDR_W +: ADDR_W];
      wd[k]    = bus.wr_data[k*DATA_W +: DATA_W];
      w_ok[k]  = idle && bus.wr_en[k] && (wa[k] != '0) && in_range(wa[k]) && digits_ok(wd[k]);
      w_bad[k] = idle && bus.wr_en[k] && !digits_ok(wd[k]);
    end
  end

  assign rsv_ok_c = idle && ((bus.rsv_addr == '0) || !in_range(bus.rsv_addr) || !sb_q[bus.rsv_addr]);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sb_d    = sb_q;
    err_d   = err_q;
    regs_d  = regs_q;
    if (state_q == CLEAR) begin
      regs_d[ptr_q] = '0;
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST) begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    end else begin
      // Ascending port order lets the highest-indexed port win on collisions.
      for (int k = 0; k < NUM_WR; k++) begin
        if (w_ok[k]) begin
          regs_d[wa[k]] = wd[k];
          if (bus.wr_release[k]) sb_d[wa[k]] = 1'b0;
        end
        if (w_bad[k]) err_d = 1'b1;
      end
      if (bus.rsv_en && rsv_ok_c && (bus.rsv_addr != '0) && in_range(bus.rsv_addr))
        sb_d[bus.rsv_addr] = 1'b1;
      if (bus.clear_req) begin
        state_d = CLEAR;
        ptr_d   = '0;
        sb_d    = '0;
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      sb_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sb_q    <= sb_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    rd_data_c  = '0;
    rd_valid_c = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];
      if (idle) begin
        if ((ra[p] == '0) || !in_range(ra[p])) begin
          rd_valid_c[p] = 1'b1;
        end else begin
          rd_data_c[p*DATA_W +: DATA_W] = regs_q[ra[p]];
          rd_valid_c[p] = !sb_q[ra[p]];
          for (int k = 0; k < NUM_WR; k++) begin
            if (w_ok[k] && (wa[k] == ra[p])) begin
              rd_data_c[p*DATA_W +: DATA_W] = wd[k];
              rd_valid_c[p] = 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.rd_data    = rd_data_c;
  assign bus.rd_valid   = rd_valid_c;
  assign bus.rsv_ok     = rsv_ok_c;
  assign bus.busy       = !idle;
  assign bus.err_sticky = err_q;
endmodule

// File: tb/tb_pentary_regfile_mp.sv
// tb/tb_pentary_regfile_mp.sv - scoreboard bench for pentary_regfile_mp against a behavioural model
module tb_pentary_regfile_mp;
  localparam int DIGITS = 16;
  localparam int NR     = 32;
  localparam int AW     = 5;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int DW     = 3 * DIGITS;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pentary_regfile_mp_if #(.DIGITS(DIGITS), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR)) bus();

  pentary_regfile_mp #(.DIGITS(DIGITS), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] data [NRD];
    logic          valid [NRD];
    logic          rsv_ok;
    logic          busy;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  logic [AW-1:0] s_rd_addr [NRD];
  logic          s_wr_en [NWR];
  logic [AW-1:0] s_wr_addr [NWR];
  logic [DW-1:0] s_wr_data [NWR];
  logic          s_wr_rel [NWR];
  logic          s_rsv_en, s_clear, s_reset;
  logic [AW-1:0] s_rsv_addr;

  logic [DW-1:0] m_mem [NR];
  bit            m_rsv [NR];
  int            m_busy;
  bit            m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("rd_data%0d", p), 64'(bus.rd_data[p*DW +: DW]), 64'(e.data[p]));
        chk($sformatf("rd_valid%0d", p), 64'(bus.rd_valid[p]), 64'(e.valid[p]));
      end
      chk("rsv_ok", 64'(bus.rsv_ok), 64'(e.rsv_ok));
      chk("busy", 64'(bus.busy), 64'(e.busy));
      chk("err_sticky", 64'(bus.err_sticky), 64'(e.err));
    end
  end

  function automatic bit m_digits_ok(input logic [DW-1:0] d);
    for (int i = 0; i < DIGITS; i++)
      if (((d >> (3*i)) & 48'h7) > 48'h4) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_wvalid(input int k);
    return s_wr_en[k] && (s_wr_addr[k] != 0) && (int'(s_wr_addr[k]) < NR) && m_digits_ok(s_wr_data[k]);
  endfunction

  task automatic m_init();
    for (int i = 0; i < NR; i++) begin
      m_mem[i] = '0;
      m_rsv[i] = 1'b0;
    end
    m_busy = NR;
    m_err  = 1'b0;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < NRD; p++) s_rd_addr[p] = '0;
    for (int k = 0; k < NWR; k++) begin
      s_wr_en[k] = 1'b0; s_wr_addr[k] = '0; s_wr_data[k] = '0; s_wr_rel[k] = 1'b0;
    end
    s_rsv_en = 1'b0; s_rsv_addr = '0; s_clear = 1'b0; s_reset = 1'b0;
  endtask

  task automatic do_cycle();
    exp_t e;
    int a;
    bit ok;
    @(negedge clk);
    for (int p = 0; p < NRD; p++) bus.rd_addr[p*AW +: AW] = s_rd_addr[p];
    for (int k = 0; k < NWR; k++) begin
      bus.wr_en[k] = s_wr_en[k];
      bus.wr_addr[k*AW +: AW] = s_wr_addr[k];
      bus.wr_data[k*DW +: DW] = s_wr_data[k];
      bus.wr_release[k] = s_wr_rel[k];
    end
    bus.rsv_en = s_rsv_en; bus.rsv_addr = s_rsv_addr; bus.clear_req = s_clear;
    reset = s_reset;
    if (s_reset) m_init();
    #1;
    for (int p = 0; p < NRD; p++) begin
      a = int'(s_rd_addr[p]);
      e.data[p] = '0;
      e.valid[p] = 1'b0;
      if (m_busy == 0) begin
        if (a == 0 || a >= NR) e.valid[p] = 1'b1;
        else begin
          e.data[p] = m_mem[a];
          e.valid[p] = !m_rsv[a];
          for (int k = 0; k < NWR; k++)
            if (m_wvalid(k) && int'(s_wr_addr[k]) == a) begin
              e.data[p] = s_wr_data[k];
              e.valid[p] = 1'b1;
            end
        end
      end
    end
    ok = (m_busy == 0) && (s_rsv_addr == 0 || !m_rsv[s_rsv_addr]);
    e.rsv_ok = ok;
    e.busy = (m_busy != 0);
    e.err = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    if (!s_reset) begin
      if (m_busy > 0) m_busy--;
      else begin
        for (int k = 0; k < NWR; k++) begin
          if (m_wvalid(k)) begin
            m_mem[s_wr_addr[k]] = s_wr_data[k];
            if (s_wr_rel[k]) m_rsv[s_wr_addr[k]] = 1'b0;
          end
          if (s_wr_en[k] && !m_digits_ok(s_wr_data[k])) m_err = 1'b1;
        end
        if (s_rsv_en && ok && s_rsv_addr != 0) m_rsv[s_rsv_addr] = 1'b1;
        if (s_clear) m_init();
      end
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < DIGITS; i++) d[3*i +: 3] = 3'($urandom_range(0, 4));
    if ($urandom_range(0, 15) == 0) d[3*$urandom_range(0, DIGITS-1) +: 3] = 3'($urandom_range(5, 7));
    return d;
  endfunction

  task automatic rand_inputs(input bit allow_ctl);
    for (int p = 0; p < NRD; p++) s_rd_addr[p] = AW'($urandom_range(0, 15));
    for (int k = 0; k < NWR; k++) begin
      s_wr_en[k]   = 1'($urandom_range(0, 1));
      s_wr_addr[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR-1)) : AW'($urandom_range(0, 15));
      s_wr_data[k] = rand_data();
      s_wr_rel[k]  = 1'($urandom_range(0, 1));
    end
    s_rsv_en   = 1'($urandom_range(0, 1));
    s_rsv_addr = AW'($urandom_range(0, 15));
    s_clear    = allow_ctl && ($urandom_range(0, 149) == 0);
    s_reset    = allow_ctl && ($urandom_range(0, 399) == 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    m_init();
    s_reset = 1'b1;
    repeat (2) do_cycle();
    s_reset = 1'b0;
    s_rd_addr[0] = 5; s_rd_addr[1] = 7;
    repeat (NR) do_cycle();
    for (int i = 0; i < NR/2; i++) begin
      s_rd_addr[0] = AW'(i); s_rd_addr[1] = AW'(i + NR/2);
      do_cycle();
    end
    idle_inputs();
    s_wr_en[0] = 1; s_wr_addr[0] = 5; s_wr_data[0] = 48'h124; s_rd_addr[0] = 5;
    do_cycle();
    idle_inputs(); s_rd_addr[0] = 5; do_cycle();
    s_wr_en[0] = 1; s_wr_addr[0] = 7; s_wr_data[0] = 48'h1;
    s_wr_en[1] = 1; s_wr_addr[1] = 7; s_wr_data[1] = 48'h2;
    do_cycle();
    idle_inputs(); s_rd_addr[0] = 7; s_rd_addr[1] = 0;
    s_wr_en[0] = 1; s_wr_addr[0] = 0; s_wr_data[0] = 48'h3;
    do_cycle();
    idle_inputs(); s_rd_addr[0] = 0; s_rd_addr[1] = 7; do_cycle();
    s_rsv_en = 1; s_rsv_addr = 9; do_cycle();
    idle_inputs(); s_rd_addr[0] = 9; s_rsv_addr = 9; do_cycle();
    s_wr_en[0] = 1; s_wr_addr[0] = 9; s_wr_data[0] = 48'h43; s_wr_rel[0] = 1; do_cycle();
    idle_inputs(); s_rd_addr[0] = 9; s_rsv_addr = 9; do_cycle();
    s_rsv_en = 1; s_wr_en[1] = 1; s_wr_addr[1] = 9; s_wr_data[1] = 48'h11; s_wr_rel[1] = 1; do_cycle();
    idle_inputs(); s_rd_addr[0] = 9; s_rsv_addr = 9; do_cycle();
    s_wr_en[0] = 1; s_wr_addr[0] = 9; s_wr_data[0] = 48'h2; s_wr_rel[0] = 1; do_cycle();
    idle_inputs(); s_wr_en[0] = 1; s_wr_addr[0] = 3; s_wr_data[0] = 48'h5; s_rd_addr[0] = 3; do_cycle();
    idle_inputs(); s_rd_addr[0] = 3; do_cycle();
    s_clear = 1; do_cycle();
    s_clear = 0; repeat (NR + 2) do_cycle();
    s_clear = 1; do_cycle();
    s_clear = 0; repeat (10) do_cycle();
    s_reset = 1; do_cycle();
    for (int i = 0; i < NR + 2; i++) begin
      rand_inputs(1'b0);
      do_cycle();
    end
    idle_inputs();
    for (int i = 0; i < NR/2; i++) begin
      s_rd_addr[0] = AW'(i); s_rd_addr[1] = AW'(i + NR/2);
      do_cycle();
    end
    for (int i = 0; i < 700; i++) begin
      rand_inputs(1'b1);
      do_cycle();
    end
    idle_inputs();
    do_cycle();
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
